matmul_job_scheduler: RTL and testbench
=======================================

# matmul_job_scheduler

- Sequences 2x2 matrix-multiply jobs through the `loader2x2` datapath.
- Queues job descriptors (A, B, C base addresses) from the host side and starts the loader one job at a time.
- Steers the loader's `start_address` through the A, B and C phases.
- Answers the loader's `next_matrix` requests and counts completed jobs.
- Includes a per-phase watchdog against a hung memory or loader.

## Interface
Parameters:
- `ADDR_WIDTH`, 15, width of the word address into matrix memory.
- `QUEUE_DEPTH`, 4, job FIFO depth; must be a power of two, at least 2.
- `TIMEOUT`, 1024, maximum cycles spent in any wait state; 0 disables the watchdog.

Ports:
- `clock`  in  1  single clock; one clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `job_valid`  in  1  host offers a job.
- `job_ready`  out  1  job accepted when `job_valid && job_ready`.
- `job_addr_a`  in  ADDR_WIDTH  base address of matrix A (4 words).
- `job_addr_b`  in  ADDR_WIDTH  base address of matrix B.
- `job_addr_c`  in  ADDR_WIDTH  base address for result C.
- `clear_error`  in  1  clears `error`.
- `loader_enable`  out  1  one-cycle start pulse to the loader.
- `loader_start_address`  out  ADDR_WIDTH  current phase base address.
- `loader_next_matrix`  in  1  loader requests the next base address (level).
- `loader_next_matrix_ready`  out  1  one-cycle grant of that request.
- `loader_done`  in  1  loader finished writing C (pulse).
- `busy`  out  1  state not IDLE, or queue non-empty.
- `job_done`  out  1  one-cycle pulse per completed job.
- `jobs_completed`  out  16  completed-job counter; wraps at 65535 to 0.
- `error`  out  1  sticky: watchdog expiry or protocol violation.

## Operation
- Job FIFO:
  - Holds `QUEUE_DEPTH` entries of 3×ADDR_WIDTH bits.
  - `job_ready = !full`; a push while full is impossible.
  - A pop while full frees a slot only on the next cycle; no same-cycle push-through.
- Request arming:
  - `req_armed` is set whenever `loader_next_matrix` is low and cleared on every grant.
  - A request counts only when `loader_next_matrix && req_armed`.
  - The loader must drop `loader_next_matrix` for at least 1 cycle between the A→B and B→C requests.
- FSM states: IDLE, START, LOAD_A, LOAD_B, STORE_C.
  - IDLE: if the FIFO is non-empty, pop it, latch the three addresses, set `loader_start_address <= addr_a` → START.
  - START: `loader_enable` = 1 for this cycle only → LOAD_A.
  - LOAD_A: on a counted request, pulse `loader_next_matrix_ready` and set `loader_start_address <= addr_b` → LOAD_B.
  - LOAD_B: on a counted request, pulse ready and set `loader_start_address <= addr_c` → STORE_C.
  - STORE_C: on `loader_done`, pulse `job_done`, increment `jobs_completed` → IDLE.
- Protocol error: `loader_done` in LOAD_A or LOAD_B sets `error`, abandons the job (no `job_done`, no count) → IDLE.
- Requests in IDLE, START or STORE_C are ignored; they are not granted.
- Watchdog:
  - Counter cleared on every state entry; counts in LOAD_A, LOAD_B and STORE_C.
  - On reaching `TIMEOUT`: set `error`, abandon the job → IDLE.
  - Queued jobs continue afterwards; the host inspects `error`.
- `clear_error` clears `error` the next cycle. If a new error event occurs in the same cycle, the set wins.
- `loader_start_address` holds its value in IDLE, so the loader never sees an undefined address.

## Timing
- Reset values:
  - `loader_enable`, `loader_next_matrix_ready`, `job_done`, `error`, `busy` = 0.
  - `jobs_completed` = 0, `loader_start_address` = 0, FIFO empty, state IDLE, `req_armed` = 1.
  - `job_ready` = 0 while `reset` is high, 1 on the first cycle after.
- Reset mid-job: the job and the queue are discarded, no `job_done`; the loader is reset by the same signal.
- All outputs are registered except `job_ready` (from full flag) and `busy` (from state plus empty flag).
- Latency from accepted push (edge N) into an empty queue with the FSM in IDLE:
  - Pop at edge N+1 (state = START).
  - `loader_enable` high during cycle N+1 to N+2.
- Address update: the address changes on the same edge the ready pulse rises, so it is stable before the loader's next fetch.
- Next job: earliest `loader_enable` is 2 cycles after `job_done`, giving the loader one idle cycle.

## Structure
- Shared package `matmul_pkg` holds:
  - ADDR_WIDTH default.
  - The job descriptor struct {addr_a, addr_b, addr_c}.
  - FSM state encoding (3 bits).
  - Counter width 16.
- Sub-module `job_fifo`: synchronous FIFO with registered pointers and `count`, parameterised on width and depth.
- Top level: FSM, `req_armed`, watchdog and counters.

## Test plan
- Single job, A=0x0010, B=0x0020, C=0x0030, behavioural loader model:
  - Address sequence 0x0010 → 0x0020 → 0x0030.
  - Exactly two ready pulses, one `loader_enable`.
  - `job_done` once, `jobs_completed` = 1.
- Push 5 jobs back-to-back, depth 4, FSM stalled in LOAD_A:
  - `job_ready` drops after the 4th stored entry.
  - All 5 jobs complete in order; counter = 5.
- Loader holds `next_matrix` high without dropping after the first grant → no second grant; watchdog (TIMEOUT=16) sets `error` after 16 cycles in LOAD_B, FSM returns to IDLE.
- `loader_done` injected during LOAD_A:
  - `error` = 1, `job_done` stays 0, counter unchanged.
  - Next queued job starts normally.
- Assert `reset` in STORE_C with 2 jobs queued:
  - Next cycle all outputs are at reset values, queue empty, `busy` = 0.
  - `clear_error` and a new error in the same cycle leave `error` = 1.
- Preload `jobs_completed` to 65535 by running jobs (or by force) → next completion gives 0.

Source files
------------

// File: rtl/matmul_job_scheduler_pkg.sv
// matmul_pkg: shared types and constants for the matmul job scheduler
package matmul_pkg;
  localparam int DEF_ADDR_WIDTH = 15;
  localparam int CNT_WIDTH = 16;
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr_a;
    logic [DEF_ADDR_WIDTH-1:0] addr_b;
    logic [DEF_ADDR_WIDTH-1:0] addr_c;
  } job_t;
  typedef enum logic [2:0] {S_IDLE, S_START, S_LOAD_A, S_LOAD_B, S_STORE_C} state_t;
  function automatic logic is_wait(state_t s);
    return s inside {S_LOAD_A, S_LOAD_B, S_STORE_C};
  endfunction
endpackage

// File: rtl/matmul_job_scheduler_if.sv
// matmul_job_scheduler_if: host job handshake and loader control bundle
interface matmul_job_scheduler_if #(parameter int ADDR_WIDTH = matmul_pkg::DEF_ADDR_WIDTH);
  import matmul_pkg::*;
  logic                  job_valid;
  logic                  job_ready;
  logic [ADDR_WIDTH-1:0] job_addr_a;
  logic [ADDR_WIDTH-1:0] job_addr_b;
  logic [ADDR_WIDTH-1:0] job_addr_c;
  logic                  clear_error;
  logic                  loader_enable;
  logic [ADDR_WIDTH-1:0] loader_start_address;
  logic                  loader_next_matrix;
  logic                  loader_next_matrix_ready;
  logic                  loader_done;
  logic                  busy;
  logic                  job_done;
  logic [CNT_WIDTH-1:0]  jobs_completed;
  logic                  error;
  modport slave (
    input  job_valid, job_addr_a, job_addr_b, job_addr_c, clear_error, loader_next_matrix, loader_done,
    output job_ready, loader_enable, loader_start_address, loader_next_matrix_ready, busy, job_done,
           jobs_completed, error
  );
  modport master (
    output job_valid, job_addr_a, job_addr_b, job_addr_c, clear_error, loader_next_matrix, loader_done,
    input  job_ready, loader_enable, loader_start_address, loader_next_matrix_ready, busy, job_done,
           jobs_completed, error
  );
endinterface

// File: rtl/matmul_job_scheduler_fifo.sv
// job_fifo: synchronous job descriptor FIFO with registered pointers and count
module job_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr;
  logic [PW-1:0]    r_rd;
  logic [PW:0]      r_count;
  logic             w_push;
  logic             w_pop;
  assign o_full  = r_count == (PW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_data  = r_mem[r_rd];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  // pointer and occupancy update; full/empty follow the registered count so a pop frees space next cycle
  always_ff @(posedge clock)
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_mem[r_wr] <= i_data;
      r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
endmodule

// File: rtl/matmul_job_scheduler.sv
// matmul_job_scheduler: queues 2x2 matmul jobs and sequences the loader through A, B and C phases
module matmul_job_scheduler
  import matmul_pkg::*;
#(
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int QUEUE_DEPTH = 4,
  parameter int TIMEOUT     = 1024
) (
  input logic                   clock,
  input logic                   reset,
  matmul_job_scheduler_if.slave bus
);
  localparam int JW = 3 * ADDR_WIDTH;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_start_address;
  logic [ADDR_WIDTH-1:0] r_addr_b;
  logic [ADDR_WIDTH-1:0] r_addr_c;
  logic                  r_enable;
  logic                  r_ready;
  logic                  r_job_done;
  logic                  r_error;
  logic                  r_req_armed;
  logic                  r_settle;
  logic [CNT_WIDTH-1:0]  r_jobs_completed;
  logic [31:0]           r_wd;
  logic [JW-1:0]         w_head;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_bad_done;
  logic                  w_finish;
  logic                  w_timeout;
  logic                  w_abort;
  job_fifo #(.WIDTH(JW), .DEPTH(QUEUE_DEPTH)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .i_push (w_push),
    .i_data ({bus.job_addr_a, bus.job_addr_b, bus.job_addr_c}),
    .i_pop  (w_pop),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty)
  );
  assign bus.job_ready                = ~w_full & ~reset;
  assign bus.busy                     = (r_state != S_IDLE) | ~w_empty;
  assign bus.loader_enable            = r_enable;
  assign bus.loader_start_address     = r_start_address;
  assign bus.loader_next_matrix_ready = r_ready;
  assign bus.job_done                 = r_job_done;
  assign bus.jobs_completed           = r_jobs_completed;
  assign bus.error                    = r_error;
  assign w_push     = bus.job_valid & bus.job_ready;
  assign w_pop      = (r_state == S_IDLE) & ~r_settle & ~w_empty;
  assign w_req      = bus.loader_next_matrix & r_req_armed;
  assign w_bad_done = bus.loader_done & (r_state inside {S_LOAD_A, S_LOAD_B});
  assign w_grant    = w_req & ~w_bad_done & (r_state inside {S_LOAD_A, S_LOAD_B});
  assign w_finish   = bus.loader_done & (r_state == S_STORE_C);
  assign w_timeout  = (TIMEOUT != 0) && (r_wd == 32'(TIMEOUT - 1)) && is_wait(r_state);
  assign w_abort    = w_bad_done | (w_timeout & ~w_grant & ~w_finish);
  // a request is armed again only after the loader drops next_matrix
  always_ff @(posedge clock)
    r_req_armed <= reset ? 1'b1 : w_grant ? 1'b0 : ~bus.loader_next_matrix ? 1'b1 : r_req_armed;
  // watchdog restarts on every state change and counts only while waiting on the loader
  always_ff @(posedge clock)
    r_wd <= (reset || !is_wait(r_state) || w_grant || w_abort || w_finish) ? 32'd0 : r_wd + 32'd1;
  // sticky error; a fresh error event beats clear_error in the same cycle
  always_ff @(posedge clock)
    r_error <= reset ? 1'b0 : w_abort ? 1'b1 : bus.clear_error ? 1'b0 : r_error;
  // job sequencer: every return to IDLE holds one settle cycle so the loader sees a gap between jobs
  always_ff @(posedge clock)
    if (reset) begin
      r_state          <= S_IDLE;
      r_start_address  <= '0;
      r_addr_b         <= '0;
      r_addr_c         <= '0;
      r_enable         <= 1'b0;
      r_ready          <= 1'b0;
      r_job_done       <= 1'b0;
      r_jobs_completed <= '0;
      r_settle         <= 1'b0;
    end else begin
      r_enable   <= 1'b0;
      r_ready    <= 1'b0;
      r_job_done <= 1'b0;
      if (w_abort) begin
        r_state  <= S_IDLE;
        r_settle <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_settle <= 1'b0;
            if (w_pop) begin
              r_state         <= S_START;
              r_enable        <= 1'b1;
              r_start_address <= w_head[JW-1 -: ADDR_WIDTH];
              r_addr_b        <= w_head[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
              r_addr_c        <= w_head[ADDR_WIDTH-1:0];
            end
          end
          S_START: r_state <= S_LOAD_A;
          S_LOAD_A: if (w_grant) begin
            r_ready         <= 1'b1;
            r_start_address <= r_addr_b;
            r_state         <= S_LOAD_B;
          end
          S_LOAD_B: if (w_grant) begin
            r_ready         <= 1'b1;
            r_start_address <= r_addr_c;
            r_state         <= S_STORE_C;
          end
          S_STORE_C: if (w_finish) begin
            r_job_done       <= 1'b1;
            r_jobs_completed <= r_jobs_completed + 1'b1;
            r_state          <= S_IDLE;
            r_settle         <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_matmul_job_scheduler.sv
// tb_matmul_job_scheduler: randomized scenario bench with a behavioural loader and job queue model
module tb_matmul_job_scheduler;
  import matmul_pkg::*;
  localparam int AW = DEF_ADDR_WIDTH;
  localparam int TO = 16;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  int          n_pass = 0;
  int          n_total = 0;
  int          n_en = 0;
  int          n_rdy = 0;
  int          n_done = 0;
  logic [15:0] exp_jobs = '0;
  job_t        q[$];
  matmul_job_scheduler_if #(.ADDR_WIDTH(AW)) bus();
  matmul_job_scheduler #(.ADDR_WIDTH(AW), .QUEUE_DEPTH(4), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  always #5 clock = ~clock;
  // pulse counters for enable, ready and job_done
  always @(posedge clock) begin
    n_en   += int'(bus.loader_enable);
    n_rdy  += int'(bus.loader_next_matrix_ready);
    n_done += int'(bus.job_done);
  end
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  function automatic job_t rand_job();
    job_t j;
    j.addr_a = AW'($urandom);
    j.addr_b = AW'($urandom);
    j.addr_c = AW'($urandom);
    return j;
  endfunction
  task automatic push_job(input job_t j, output bit acc);
    bus.job_valid  = 1'b1;
    bus.job_addr_a = j.addr_a;
    bus.job_addr_b = j.addr_b;
    bus.job_addr_c = j.addr_c;
    acc = bus.job_ready;
    @(negedge clock);
    bus.job_valid = 1'b0;
    if (acc) q.push_back(j);
  endtask
  task automatic wait_enable();
    for (int k = 0; k < 40 && !bus.loader_enable; k++) @(negedge clock);
    n_total++;
    if (bus.loader_enable !== 1'b1) $display("FAIL enable_wait: loader_enable=%b required 1", bus.loader_enable);
    else n_pass++;
  endtask
  task automatic request(input logic [AW-1:0] exp_addr, input string name);
    repeat ($urandom_range(1, 3)) @(negedge clock);
    bus.loader_next_matrix = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (bus.loader_next_matrix_ready) break;
    end
    bus.loader_next_matrix = 1'b0;
    n_total++;
    if (bus.loader_next_matrix_ready !== 1'b1 || bus.loader_start_address !== exp_addr)
      $display("FAIL %s: ready=%b addr=%h required ready=1 addr=%h", name, bus.loader_next_matrix_ready,
               bus.loader_start_address, exp_addr);
    else n_pass++;
  endtask
  task automatic run_job(input job_t j, input bit started, input bit finish);
    if (!started) wait_enable();
    n_total++;
    if (bus.loader_start_address !== j.addr_a)
      $display("FAIL addr_a: got %h required %h", bus.loader_start_address, j.addr_a);
    else n_pass++;
    request(j.addr_b, "grant_b");
    request(j.addr_c, "grant_c");
    if (finish) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      bus.loader_done = 1'b1;
      @(negedge clock);
      bus.loader_done = 1'b0;
      exp_jobs++;
      n_total++;
      if (bus.job_done !== 1'b1 || bus.jobs_completed !== exp_jobs)
        $display("FAIL job_complete: job_done=%b count=%0d required 1/%0d", bus.job_done, bus.jobs_completed, exp_jobs);
      else n_pass++;
    end
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_total++;
    if (bus.job_ready !== 1'b0) $display("FAIL reset_job_ready: got %b required 0", bus.job_ready);
    else n_pass++;
    n_total++;
    if ({bus.loader_enable, bus.loader_next_matrix_ready, bus.job_done, bus.error, bus.busy} !== 5'b0 ||
        bus.jobs_completed !== 16'd0 || bus.loader_start_address !== '0)
      $display("FAIL reset_outputs: en=%b rdy=%b done=%b err=%b busy=%b cnt=%0d addr=%h required all 0",
               bus.loader_enable, bus.loader_next_matrix_ready, bus.job_done, bus.error, bus.busy,
               bus.jobs_completed, bus.loader_start_address);
    else n_pass++;
    reset = 1'b0;
    @(negedge clock);
    n_total++;
    if (bus.job_ready !== 1'b1) $display("FAIL post_reset_job_ready: got %b required 1", bus.job_ready);
    else n_pass++;
  endtask
  task automatic test_single();
    job_t j;
    bit acc;
    int e0, r0, d0;
    e0 = n_en; r0 = n_rdy; d0 = n_done;
    j.addr_a = AW'(16'h0010);
    j.addr_b = AW'(16'h0020);
    j.addr_c = AW'(16'h0030);
    push_job(j, acc);
    n_total++;
    if (bus.loader_enable !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL single_push_cycle: en=%b busy=%b required 0/1", bus.loader_enable, bus.busy);
    else n_pass++;
    @(negedge clock);
    n_total++;
    if (bus.loader_enable !== 1'b1) $display("FAIL single_latency: enable=%b required 1", bus.loader_enable);
    else n_pass++;
    run_job(q.pop_front(), 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    n_total++;
    if (n_en - e0 != 1 || n_rdy - r0 != 2 || n_done - d0 != 1 || bus.busy !== 1'b0)
      $display("FAIL single_pulses: en=%0d rdy=%0d done=%0d busy=%b required 1/2/1/0", n_en - e0, n_rdy - r0,
               n_done - d0, bus.busy);
    else n_pass++;
  endtask
  task automatic test_back_to_back();
    bit acc;
    for (int i = 0; i < 5; i++) begin
      push_job(rand_job(), acc);
      n_total++;
      if (acc !== 1'b1) $display("FAIL b2b_accept_%0d: job_ready=%b required 1", i, acc);
      else n_pass++;
    end
    n_total++;
    if (bus.job_ready !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL b2b_full: job_ready=%b busy=%b required 0/1", bus.job_ready, bus.busy);
    else n_pass++;
    for (int i = 0; i < 5; i++) run_job(q.pop_front(), i == 0, 1'b1);
    repeat (3) @(negedge clock);
    n_total++;
    if (bus.jobs_completed !== exp_jobs || bus.busy !== 1'b0)
      $display("FAIL b2b_count: count=%0d busy=%b required %0d/0", bus.jobs_completed, bus.busy, exp_jobs);
    else n_pass++;
  endtask
  task automatic test_watchdog();
    bit acc;
    job_t j;
    int k, r0, d0;
    push_job(rand_job(), acc);
    j = q.pop_front();
    wait_enable();
    r0 = n_rdy; d0 = n_done;
    request(j.addr_b, "wd_grant_b");
    bus.loader_next_matrix = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (bus.error) break;
    end
    n_total++;
    if (k != TO) $display("FAIL watchdog_cycles: error after %0d cycles required %0d", k, TO);
    else n_pass++;
    n_total++;
    if (bus.busy !== 1'b0 || bus.jobs_completed !== exp_jobs)
      $display("FAIL watchdog_idle: busy=%b count=%0d required 0/%0d", bus.busy, bus.jobs_completed, exp_jobs);
    else n_pass++;
    bus.loader_next_matrix = 1'b0;
    bus.clear_error = 1'b1;
    @(negedge clock);
    bus.clear_error = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if (bus.error !== 1'b0 || n_rdy - r0 != 1 || n_done != d0)
      $display("FAIL watchdog_after: err=%b grants=%0d dones=%0d required 0/1/0", bus.error, n_rdy - r0, n_done - d0);
    else n_pass++;
  endtask
  task automatic test_protocol();
    bit acc;
    job_t j0;
    int d0;
    d0 = n_done;
    push_job(rand_job(), acc);
    push_job(rand_job(), acc);
    j0 = q.pop_front();
    wait_enable();
    if ($urandom_range(0, 1)) begin
      @(negedge clock);
    end else begin
      request(j0.addr_b, "proto_grant_b");
    end
    bus.loader_done = 1'b1;
    @(negedge clock);
    bus.loader_done = 1'b0;
    n_total++;
    if (bus.error !== 1'b1 || bus.job_done !== 1'b0 || bus.jobs_completed !== exp_jobs)
      $display("FAIL protocol_error: err=%b done=%b count=%0d required 1/0/%0d", bus.error, bus.job_done,
               bus.jobs_completed, exp_jobs);
    else n_pass++;
    run_job(q.pop_front(), 1'b0, 1'b1);
    bus.clear_error = 1'b1;
    @(negedge clock);
    bus.clear_error = 1'b0;
    repeat (2) @(negedge clock);
    n_total++;
    if (n_done - d0 != 1 || bus.error !== 1'b0)
      $display("FAIL protocol_next: dones=%0d err=%b required 1/0", n_done - d0, bus.error);
    else n_pass++;
  endtask
  task automatic test_reset_mid();
    bit acc;
    int e0;
    for (int i = 0; i < 3; i++) push_job(rand_job(), acc);
    run_job(q.pop_front(), 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    q.delete();
    exp_jobs = '0;
    n_total++;
    if ({bus.loader_enable, bus.loader_next_matrix_ready, bus.job_done, bus.error, bus.busy, bus.job_ready} !== 6'b0 ||
        bus.jobs_completed !== 16'd0 || bus.loader_start_address !== '0)
      $display("FAIL reset_mid: en=%b rdy=%b done=%b err=%b busy=%b jr=%b cnt=%0d addr=%h required all 0",
               bus.loader_enable, bus.loader_next_matrix_ready, bus.job_done, bus.error, bus.busy, bus.job_ready,
               bus.jobs_completed, bus.loader_start_address);
    else n_pass++;
    reset = 1'b0;
    e0 = n_en;
    repeat (5) @(negedge clock);
    n_total++;
    if (n_en != e0 || bus.busy !== 1'b0) $display("FAIL reset_mid_queue: enables=%0d busy=%b required 0/0", n_en - e0, bus.busy);
    else n_pass++;
    push_job(rand_job(), acc);
    void'(q.pop_front());
    wait_enable();
    @(negedge clock);
    bus.loader_done = 1'b1;
    bus.clear_error = 1'b1;
    @(negedge clock);
    bus.loader_done = 1'b0;
    bus.clear_error = 1'b0;
    n_total++;
    if (bus.error !== 1'b1) $display("FAIL set_beats_clear: err=%b required 1", bus.error);
    else n_pass++;
    bus.clear_error = 1'b1;
    @(negedge clock);
    bus.clear_error = 1'b0;
    n_total++;
    if (bus.error !== 1'b0) $display("FAIL clear_error: err=%b required 0", bus.error);
    else n_pass++;
    repeat (2) @(negedge clock);
  endtask
  task automatic test_wrap();
    bit acc;
    force dut.r_jobs_completed = 16'hFFFF;
    @(negedge clock);
    release dut.r_jobs_completed;
    exp_jobs = 16'hFFFF;
    @(negedge clock);
    n_total++;
    if (bus.jobs_completed !== 16'hFFFF) $display("FAIL wrap_preload: count=%0d required 65535", bus.jobs_completed);
    else n_pass++;
    push_job(rand_job(), acc);
    run_job(q.pop_front(), 1'b0, 1'b1);
    n_total++;
    if (bus.jobs_completed !== 16'd0) $display("FAIL wrap_zero: count=%0d required 0", bus.jobs_completed);
    else n_pass++;
  endtask
  initial begin
    bus.job_valid          = 1'b0;
    bus.job_addr_a         = '0;
    bus.job_addr_b         = '0;
    bus.job_addr_c         = '0;
    bus.clear_error        = 1'b0;
    bus.loader_next_matrix = 1'b0;
    bus.loader_done        = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_watchdog();
    test_protocol();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
